pe_mac_sched: RTL and testbench
===============================

Name: pe_mac_sched

Overview:
- Sequencer for one pe MAC element.
- Computes N outputs of a stride-1, 1-D sliding dot product of length K.
- Fetches data and weight operands from two on-chip buffers and issues one MAC per tap to the PE.
- Feeds the running partial sum back on i_psum, captures o_psum, and emits each finished result over a valid/ready port toward the output buffer.

Parameters:
- BIT_WIDTH, 8: operand, psum and result width; matches the pe BIT_WIDTH.
- MUL_LAT, 3: multiplier latency inside the pe. PE_LAT = MUL_LAT+1 = cycles from PE data_val to psum_val.
- ADDR_WIDTH, 10: data and weight buffer address width.
- LEN_WIDTH, 8: width of the K and N configuration fields.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_len  in  LEN_WIDTH  K, taps per output; latched at start.
- i_num_out  in  LEN_WIDTH  N, outputs per job; latched at start.
- i_data_base  in  ADDR_WIDTH  data buffer base address; latched at start.
- o_busy  out  1  high from the accepted start until DONE inclusive.
- o_done  out  1  one-cycle pulse at job end.
- o_err  out  1  sticky PE-timeout flag; cleared by the next accepted start.
- o_data_addr  out  ADDR_WIDTH  data buffer read address.
- o_data_rd  out  1  data buffer read enable; read data returns the next cycle.
- i_data_rdata  in  BIT_WIDTH  data buffer read data.
- o_weight_addr  out  ADDR_WIDTH  weight buffer read address.
- o_weight_rd  out  1  weight buffer read enable; 1-cycle read latency.
- i_weight_rdata  in  BIT_WIDTH  weight buffer read data.
- o_pe_data, o_pe_weight  out  BIT_WIDTH  PE operands.
- o_pe_data_val, o_pe_weight_val  out  1  PE operand strobes.
- o_pe_psum  out  BIT_WIDTH  accumulator value presented to the PE i_psum.
- o_pe_psum_val  out  1  PE psum strobe.
- i_pe_psum  in  BIT_WIDTH  PE o_psum.
- i_pe_psum_val  in  1  PE o_psum_val.
- o_result  out  BIT_WIDTH  finished output value.
- o_result_val  out  1  result valid.
- i_result_rdy  in  1  downstream ready.

Behaviour:
- Reset: every output is 0. Internal acc, tap_cnt, out_cnt and wait_cnt are 0. FSM is in IDLE.
- IDLE:
  - An accepted i_start latches K, N and base, clears acc, tap_cnt, out_cnt and o_err, and raises o_busy.
  - If K==0 or N==0, go to DONE with no buffer reads and no PE strobes. Otherwise go to FETCH.
  - i_start outside IDLE is ignored.
- FETCH (1 cycle):
  - o_data_rd=o_weight_rd=1.
  - o_data_addr = base+out_cnt+tap_cnt, modulo 2^ADDR_WIDTH.
  - o_weight_addr = tap_cnt.
  - Next state: ISSUE.
- ISSUE (1 cycle):
  - o_pe_data=i_data_rdata, o_pe_weight=i_weight_rdata.
  - o_pe_data_val, o_pe_weight_val and o_pe_psum_val are all 1.
  - Clear wait_cnt. Next state: WAIT.
- WAIT:
  - o_pe_psum=acc, held stable for the whole state, because the PE adds i_psum combinationally at its output.
  - All PE strobes are 0.
  - On i_pe_psum_val: acc<=i_pe_psum.
    - If tap_cnt==K-1, go to OUT.
    - Otherwise tap_cnt++ and go to FETCH.
  - If wait_cnt reaches PE_LAT+3 without i_pe_psum_val: set o_err and go to DONE (job aborted).
- Tap cost is 2+PE_LAT cycles (6 at the defaults).
- OUT:
  - o_result=acc and o_result_val=1, held stable until i_result_rdy.
  - On handshake: out_cnt++, tap_cnt<=0, acc<=0.
    - If out_cnt==N-1, go to DONE.
    - Otherwise go to FETCH.
- DONE (1 cycle): o_done=1, o_busy=1. Next cycle o_busy=0 and the FSM is in IDLE.
- Arithmetic:
  - The PE produces data*weight+psum, truncated to BIT_WIDTH.
  - The sequencer adds nothing itself: acc wraps modulo 2^BIT_WIDTH, no saturation.
  - Operands are unsigned.
- i_pe_psum_val outside WAIT is ignored.
- rst asserted mid-job returns the block to its reset state at once; no o_done is produced.
- Latency per output is K*(2+PE_LAT)+1 cycles, with no backpressure, from the first FETCH to o_result_val.

Decomposition:
- Shared package: FSM state encoding (IDLE, FETCH, ISSUE, WAIT, OUT, DONE), derived PE_LAT, and the timeout margin constant (3).
- One sub-module, pe_mac_addr_gen: holds the tap_cnt and out_cnt counters and produces both addresses plus the last_tap and last_out flags.
- The FSM and accumulator stay in pe_mac_sched.
- The bench instantiates the real pe (with mult_gen_0) downstream.

Test Plan:
- Basic dot product: K=3, N=1, data=[1,2,3], weights=[4,5,6], rdy=1 → one o_result=32, o_result_val rising 19 cycles after start accept; o_done next cycle after handshake.
- Sliding window and wrap: K=2, N=3, data=[1,2,3,4], w=[1,1] → results 3, 5, 7. With K=1, data=100, w=3 → 44 (300 mod 256).
- Backpressure: hold i_result_rdy=0 for 10 cycles during OUT → o_result and o_result_val stable; no new FETCH until handshake; second result still correct.
- Degenerate and ignored start: K=0 or N=0 → o_done pulse 1 cycle after start, zero buffer reads, zero PE strobes. i_start during busy → ignored.
- Reset mid-job: assert rst during WAIT of tap 2 → all outputs 0 immediately, no o_done. A fresh job afterwards gives the correct result.
- Timeout: suppress i_pe_psum_val → o_err=1 after PE_LAT+3 WAIT cycles, then o_done pulse; next start clears o_err.

Source files
------------

// File: rtl/pe_mac_sched_pkg.sv
// pe_mac_sched_pkg
//   Shared definitions for the pe MAC sequencer slice.
//   - state_t        : sequencer FSM states
//   - TIMEOUT_MARGIN : extra WAIT cycles tolerated beyond the PE latency
//   - calc_pe_lat()  : PE data_val -> psum_val latency for a given multiplier latency
package pe_mac_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_OUT,
      ST_DONE
   } state_t;

   localparam int unsigned TIMEOUT_MARGIN = 3;

   // Multiplier pipeline plus the PE output register.
   function automatic int unsigned calc_pe_lat(input int unsigned mul_lat);
      return mul_lat + 1;
   endfunction

endpackage

// File: rtl/pe_mac_sched_if.sv
// pe_mac_sched_if
//   Bundles the sequencer's datapath-side connections:
//   - data / weight buffer read ports (address, read enable, read data)
//   - PE operand, psum and strobe lines, plus the PE psum return
//   - result valid/ready port toward the output buffer
//   master : sequencer side
//   slave  : buffers / PE / output-buffer side
interface pe_mac_sched_if #(
   parameter int unsigned BIT_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 10
) ();

   // Buffer read ports
   logic [ADDR_WIDTH-1:0] o_data_addr;
   logic                  o_data_rd;
   logic [BIT_WIDTH-1:0]  i_data_rdata;
   logic [ADDR_WIDTH-1:0] o_weight_addr;
   logic                  o_weight_rd;
   logic [BIT_WIDTH-1:0]  i_weight_rdata;

   // PE connections
   logic [BIT_WIDTH-1:0]  o_pe_data;
   logic [BIT_WIDTH-1:0]  o_pe_weight;
   logic                  o_pe_data_val;
   logic                  o_pe_weight_val;
   logic [BIT_WIDTH-1:0]  o_pe_psum;
   logic                  o_pe_psum_val;
   logic [BIT_WIDTH-1:0]  i_pe_psum;
   logic                  i_pe_psum_val;

   // Result port
   logic [BIT_WIDTH-1:0]  o_result;
   logic                  o_result_val;
   logic                  i_result_rdy;

   modport master (
      output o_data_addr, o_data_rd, o_weight_addr, o_weight_rd,
      output o_pe_data, o_pe_weight, o_pe_data_val, o_pe_weight_val,
      output o_pe_psum, o_pe_psum_val,
      output o_result, o_result_val,
      input  i_data_rdata, i_weight_rdata,
      input  i_pe_psum, i_pe_psum_val,
      input  i_result_rdy
   );

   modport slave (
      input  o_data_addr, o_data_rd, o_weight_addr, o_weight_rd,
      input  o_pe_data, o_pe_weight, o_pe_data_val, o_pe_weight_val,
      input  o_pe_psum, o_pe_psum_val,
      input  o_result, o_result_val,
      output i_data_rdata, i_weight_rdata,
      output i_pe_psum, i_pe_psum_val,
      output i_result_rdy
   );

endinterface

// File: rtl/pe_mac_addr_gen.sv
// pe_mac_addr_gen
//   Tap / output counters and buffer address generation for pe_mac_sched.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     load          : latch len / num_out / base and clear both counters
//     len, num_out  : K (taps per output) and N (outputs per job)
//     base          : data buffer base address
//     tap_inc       : advance to the next tap of the current output
//     out_inc       : advance to the next output, restart at tap 0
//     data_addr     : base + out_cnt + tap_cnt (wraps at 2^ADDR_WIDTH)
//     weight_addr   : tap_cnt
//     last_tap      : tap_cnt == K-1
//     last_out      : out_cnt == N-1
module pe_mac_addr_gen #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [LEN_WIDTH-1:0]  num_out,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic                  tap_inc,
   input  logic                  out_inc,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic [ADDR_WIDTH-1:0] weight_addr,
   output logic                  last_tap,
   output logic                  last_out
);

   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  num_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [LEN_WIDTH-1:0]  tap_cnt;
   logic [LEN_WIDTH-1:0]  out_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q   <= '0;
         num_q   <= '0;
         base_q  <= '0;
         tap_cnt <= '0;
         out_cnt <= '0;
      end else if (load) begin
         len_q   <= len;
         num_q   <= num_out;
         base_q  <= base;
         tap_cnt <= '0;
         out_cnt <= '0;
      end else if (out_inc) begin
         out_cnt <= out_cnt + LEN_WIDTH'(1);
         tap_cnt <= '0;
      end else if (tap_inc) begin
         tap_cnt <= tap_cnt + LEN_WIDTH'(1);
      end
   end

   // Stride-1 window: output o, tap t reads data[base + o + t].
   assign data_addr   = base_q + ADDR_WIDTH'(out_cnt) + ADDR_WIDTH'(tap_cnt);
   assign weight_addr = ADDR_WIDTH'(tap_cnt);

   // Only consulted mid-job, where K and N are known to be non-zero.
   assign last_tap = (tap_cnt == len_q - LEN_WIDTH'(1));
   assign last_out = (out_cnt == num_q - LEN_WIDTH'(1));

endmodule

// File: rtl/pe_mac_sched.sv
// pe_mac_sched
//   Sequencer for one pe MAC element. Computes N outputs of a stride-1 1-D
//   sliding dot product of length K: per tap it reads one data and one weight
//   operand, issues a MAC to the PE with the running sum on o_pe_psum, and
//   captures the PE result back into the accumulator. Each finished sum is
//   offered on a valid/ready result port.
//   Ports:
//     clk, rst         : clock, asynchronous active-high reset
//     i_start          : start pulse, honoured only when idle
//     i_len, i_num_out : K and N, latched at start
//     i_data_base      : data buffer base address, latched at start
//     o_busy           : job in progress (through the DONE cycle)
//     o_done           : one-cycle end-of-job pulse
//     o_err            : sticky PE-timeout flag, cleared by the next start
//     bus              : buffer / PE / result connections (master side)
module pe_mac_sched
   import pe_mac_sched_pkg::*;
#(
   parameter int unsigned BIT_WIDTH  = 8,
   parameter int unsigned MUL_LAT    = 3,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [LEN_WIDTH-1:0]  i_len,
   input  logic [LEN_WIDTH-1:0]  i_num_out,
   input  logic [ADDR_WIDTH-1:0] i_data_base,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   pe_mac_sched_if.master        bus
);

   localparam int unsigned PE_LAT     = calc_pe_lat(MUL_LAT);
   localparam int unsigned WAIT_LIMIT = PE_LAT + TIMEOUT_MARGIN;
   localparam int unsigned WAIT_W     = $clog2(WAIT_LIMIT + 1);

   state_t                 state_q, state_d;
   logic [BIT_WIDTH-1:0]   acc_q;
   logic [WAIT_W-1:0]      wait_cnt_q;
   logic                   err_q;

   logic                   ag_load, ag_tap_inc, ag_out_inc;
   logic                   acc_clr, acc_ld;
   logic                   wait_clr, wait_inc;
   logic                   err_clr, err_set;
   logic [ADDR_WIDTH-1:0]  ag_data_addr, ag_weight_addr;
   logic                   last_tap, last_out;

   pe_mac_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .load        (ag_load),
      .len         (i_len),
      .num_out     (i_num_out),
      .base        (i_data_base),
      .tap_inc     (ag_tap_inc),
      .out_inc     (ag_out_inc),
      .data_addr   (ag_data_addr),
      .weight_addr (ag_weight_addr),
      .last_tap    (last_tap),
      .last_out    (last_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;

         if (acc_clr)
            acc_q <= '0;
         else if (acc_ld)
            acc_q <= bus.i_pe_psum;

         if (wait_clr)
            wait_cnt_q <= '0;
         else if (wait_inc)
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);

         if (err_clr)
            err_q <= 1'b0;
         else if (err_set)
            err_q <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      ag_load    = 1'b0;
      ag_tap_inc = 1'b0;
      ag_out_inc = 1'b0;
      acc_clr    = 1'b0;
      acc_ld     = 1'b0;
      wait_clr   = 1'b0;
      wait_inc   = 1'b0;
      err_clr    = 1'b0;
      err_set    = 1'b0;

      o_busy = (state_q != ST_IDLE);
      o_done = 1'b0;

      bus.o_data_addr     = '0;
      bus.o_data_rd       = 1'b0;
      bus.o_weight_addr   = '0;
      bus.o_weight_rd     = 1'b0;
      bus.o_pe_data       = '0;
      bus.o_pe_weight     = '0;
      bus.o_pe_data_val   = 1'b0;
      bus.o_pe_weight_val = 1'b0;
      bus.o_pe_psum       = '0;
      bus.o_pe_psum_val   = 1'b0;
      bus.o_result        = '0;
      bus.o_result_val    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               ag_load = 1'b1;
               acc_clr = 1'b1;
               err_clr = 1'b1;
               if (i_len == '0 || i_num_out == '0)
                  state_d = ST_DONE;
               else
                  state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            bus.o_data_rd     = 1'b1;
            bus.o_weight_rd   = 1'b1;
            bus.o_data_addr   = ag_data_addr;
            bus.o_weight_addr = ag_weight_addr;
            state_d           = ST_ISSUE;
         end

         ST_ISSUE: begin
            bus.o_pe_data       = bus.i_data_rdata;
            bus.o_pe_weight     = bus.i_weight_rdata;
            bus.o_pe_data_val   = 1'b1;
            bus.o_pe_weight_val = 1'b1;
            bus.o_pe_psum       = acc_q;
            bus.o_pe_psum_val   = 1'b1;
            wait_clr            = 1'b1;
            state_d             = ST_WAIT;
         end

         ST_WAIT: begin
            // The PE adds i_psum combinationally at its output, so acc must
            // stay on the bus for as long as the result may arrive.
            bus.o_pe_psum = acc_q;
            if (bus.i_pe_psum_val) begin
               acc_ld = 1'b1;
               if (last_tap) begin
                  state_d = ST_OUT;
               end else begin
                  ag_tap_inc = 1'b1;
                  state_d    = ST_FETCH;
               end
            end else if (wait_cnt_q == WAIT_W'(WAIT_LIMIT - 1)) begin
               // WAIT_LIMIT-th WAIT cycle without a PE result: abort.
               err_set = 1'b1;
               state_d = ST_DONE;
            end else begin
               wait_inc = 1'b1;
            end
         end

         ST_OUT: begin
            bus.o_result     = acc_q;
            bus.o_result_val = 1'b1;
            if (bus.i_result_rdy) begin
               ag_out_inc = 1'b1;
               acc_clr    = 1'b1;
               state_d    = last_out ? ST_DONE : ST_FETCH;
            end
         end

         ST_DONE: begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign o_err = err_q;

endmodule

// File: tb/tb_pe_mac_sched.sv
module tb_pe_mac_sched;

   localparam int unsigned BW      = 8;
   localparam int unsigned AW      = 10;
   localparam int unsigned LW      = 8;
   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned PE_LAT  = MUL_LAT + 1;
   localparam int unsigned DEPTH   = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic [LW-1:0] num = '0;
   logic [AW-1:0] base = '0;
   logic          busy, done, err;

   pe_mac_sched_if #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

   pe_mac_sched #(
      .BIT_WIDTH  (BW),
      .MUL_LAT    (MUL_LAT),
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_len       (len),
      .i_num_out   (num),
      .i_data_base (base),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Buffers: registered read, data returns the cycle after the read.
   logic [BW-1:0] data_mem   [DEPTH];
   logic [BW-1:0] weight_mem [DEPTH];
   logic [BW-1:0] d_rdata = '0;
   logic [BW-1:0] w_rdata = '0;

   always @(posedge clk) begin
      if (bus.o_data_rd)   d_rdata <= data_mem[bus.o_data_addr];
      if (bus.o_weight_rd) w_rdata <= weight_mem[bus.o_weight_addr];
   end
   assign bus.i_data_rdata   = d_rdata;
   assign bus.i_weight_rdata = w_rdata;

   // Behavioural PE: product pipelined PE_LAT cycles, i_psum added at output.
   logic [BW-1:0]     pe_prod [PE_LAT];
   logic [PE_LAT-1:0] pe_vld = '0;
   logic              suppress = 1'b0;

   always @(posedge clk) begin
      pe_prod[0] <= bus.o_pe_data * bus.o_pe_weight;
      for (int unsigned i = 1; i < PE_LAT; i++) pe_prod[i] <= pe_prod[i-1];
      pe_vld <= {pe_vld[PE_LAT-2:0], bus.o_pe_data_val & bus.o_pe_weight_val};
   end
   assign bus.i_pe_psum     = pe_prod[PE_LAT-1] + bus.o_pe_psum;
   assign bus.i_pe_psum_val = pe_vld[PE_LAT-1] & ~suppress;

   // Downstream ready driver.
   logic hold_rdy = 1'b0;
   logic rand_rdy = 1'b0;
   initial begin
      bus.i_result_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (hold_rdy)      bus.i_result_rdy = 1'b0;
         else if (rand_rdy) bus.i_result_rdy = 1'($urandom_range(0, 1));
         else               bus.i_result_rdy = 1'b1;
      end
   end

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // Reference: result o of a job = sum_t data[(b+o+t) mod DEPTH] * w[t], mod 2^BW.
   function automatic logic [BW-1:0] ref_dot(input int unsigned k, input int unsigned o,
                                             input int unsigned b);
      int unsigned s = 0;
      for (int unsigned t = 0; t < k; t++)
         s += int'(data_mem[(b + o + t) % DEPTH]) * int'(weight_mem[t]);
      return s[BW-1:0];
   endfunction

   // Scoreboard monitor.
   logic [BW-1:0] exp_q [$];
   initial forever begin
      @(negedge clk);
      if (!rst && bus.o_result_val && bus.i_result_rdy) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_result: got %0d with no result pending", bus.o_result);
         end else begin
            chk("result", 64'(bus.o_result), 64'(exp_q.pop_front()));
         end
      end
   end

   // Event counters.
   int unsigned done_cnt = 0, rd_cnt = 0, stb_cnt = 0;
   initial forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (bus.o_data_rd || bus.o_weight_rd) rd_cnt++;
      if (bus.o_pe_data_val || bus.o_pe_weight_val || bus.o_pe_psum_val) stb_cnt++;
   end

   function automatic logic [63:0] outs_vec();
      return 64'({busy, done, err, bus.o_data_addr, bus.o_data_rd, bus.o_weight_addr,
                  bus.o_weight_rd, bus.o_pe_data, bus.o_pe_weight, bus.o_pe_data_val,
                  bus.o_pe_weight_val, bus.o_pe_psum, bus.o_pe_psum_val, bus.o_result,
                  bus.o_result_val});
   endfunction

   task automatic push_ref(input int unsigned k, input int unsigned n, input int unsigned b);
      for (int unsigned o = 0; o < n; o++) exp_q.push_back(ref_dot(k, o, b));
   endtask

   // Returns 1 ns after the edge that accepts the start.
   task automatic start_job(input int unsigned k, input int unsigned n, input int unsigned b);
      @(posedge clk); #1;
      start = 1'b1; len = LW'(k); num = LW'(n); base = AW'(b);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned limit, input string name);
      bit ok = 1'b0;
      for (int unsigned i = 0; i < limit && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
      chk(name, 64'(ok), 64'(1));
      #2;
      chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned n, d0, r0, s0;
      bit ok;

      for (int unsigned i = 0; i < DEPTH; i++) begin
         data_mem[i]   = BW'($urandom);
         weight_mem[i] = BW'($urandom);
      end

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs_vec(), 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic dot product and latency
      data_mem[10] = 1; data_mem[11] = 2; data_mem[12] = 3;
      weight_mem[0] = 4; weight_mem[1] = 5; weight_mem[2] = 6;
      exp_q.push_back(8'd32);
      start_job(3, 1, 10);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.o_result_val && n < 100);
      chk("latency_k3", 64'(n), 64'(19));
      @(negedge clk);
      chk("done_after_handshake", 64'(done), 64'(1));
      #2;
      chk("basic_queue_empty", 64'(exp_q.size()), 64'(0));

      // Sliding window
      data_mem[200] = 1; data_mem[201] = 2; data_mem[202] = 3; data_mem[203] = 4;
      weight_mem[0] = 1; weight_mem[1] = 1;
      exp_q.push_back(8'd3); exp_q.push_back(8'd5); exp_q.push_back(8'd7);
      start_job(2, 3, 200);
      wait_done(300, "sliding_done");

      // Wrap of the accumulator
      data_mem[300] = 100; weight_mem[0] = 3;
      exp_q.push_back(8'd44);
      start_job(1, 1, 300);
      wait_done(100, "wrap_done");

      // Backpressure
      push_ref(2, 2, 500);
      hold_rdy = 1'b1;
      start_job(2, 2, 500);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.o_result_val && n < 100);
      chk("bp_val_seen", 64'(bus.o_result_val), 64'(1));
      r0 = bus.o_result; ok = 1'b1;
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus.o_result_val || bus.o_result != BW'(r0) || bus.o_data_rd || bus.o_weight_rd)
            ok = 1'b0;
      end
      chk("bp_hold_stable", 64'(ok), 64'(1));
      hold_rdy = 1'b0;
      wait_done(300, "bp_done");

      // Degenerate jobs
      for (int unsigned j = 0; j < 2; j++) begin
         #2;
         d0 = rd_cnt; s0 = stb_cnt;
         start_job(j == 0 ? 0 : 3, j == 0 ? 3 : 0, 0);
         @(negedge clk);
         chk(j == 0 ? "degen_k0_done" : "degen_n0_done", 64'(done), 64'(1));
         @(negedge clk); #2;
         chk(j == 0 ? "degen_k0_idle" : "degen_n0_idle", 64'(busy), 64'(0));
         chk(j == 0 ? "degen_k0_no_access" : "degen_n0_no_access",
             64'((rd_cnt - d0) + (stb_cnt - s0)), 64'(0));
      end

      // Start while busy is ignored
      push_ref(3, 2, 700);
      start_job(3, 2, 700);
      d0 = done_cnt;
      repeat (10) @(posedge clk);
      #1; start = 1'b1; len = 1; num = 1; base = 5;
      @(posedge clk); #1; start = 1'b0;
      wait_done(400, "ignored_start_done");
      repeat (5) @(negedge clk); #2;
      chk("ignored_start_idle", 64'(busy), 64'(0));
      chk("ignored_start_one_done", 64'(done_cnt - d0), 64'(1));

      // Reset mid-job during the WAIT of the second tap
      start_job(3, 1, 50);
      n = 0; s0 = 0;
      while (s0 < 2 && n < 100) begin
         @(negedge clk); n++;
         if (bus.o_pe_data_val) s0++;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midjob_reset_outputs", outs_vec(), 64'(0));
      #2; d0 = done_cnt;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk); #2;
      chk("midjob_reset_no_done", 64'(done_cnt - d0), 64'(0));
      push_ref(3, 1, 50);
      start_job(3, 1, 50);
      wait_done(200, "after_reset_done");

      // PE timeout
      suppress = 1'b1;
      start_job(2, 1, 60);
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 50);
      chk("timeout_done_cycle", 64'(n), 64'(PE_LAT + 3 + 3));
      chk("timeout_err", 64'(err), 64'(1));
      @(negedge clk);
      suppress = 1'b0;
      push_ref(2, 1, 60);
      start_job(2, 1, 60);
      @(negedge clk);
      chk("err_cleared_by_start", 64'(err), 64'(0));
      wait_done(200, "post_timeout_done");

      // Randomized jobs with random backpressure
      rand_rdy = 1'b1;
      for (int unsigned j = 0; j < 12; j++) begin
         int unsigned k, nn, b;
         k  = (j == 0) ? 4 : $urandom_range(1, 5);
         nn = $urandom_range(1, 4);
         b  = (j == 0) ? DEPTH - 2 : $urandom_range(0, DEPTH - 1);
         push_ref(k, nn, b);
         start_job(k, nn, b);
         wait_done(2000, "random_job_done");
      end
      rand_rdy = 1'b0;

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
